// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Redirect targets are word addresses; the byte-offset bits are dropped.
  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read channel: one outstanding req/ack transaction.
// The fetch unit is the master; the memory is the slave.
interface if_fetch_unit_if;
  import mips_pkg::*;

  logic              imem_req;
  logic [INST_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its PC+4.
// Captures a word that arrived while the IF/ID slot was occupied.
// Priority: clear > load > unload.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [INST_W-1:0] data_in,
  input  logic [INST_W-1:0] pc_in,
  output logic [INST_W-1:0] data_out,
  output logic [INST_W-1:0] pc_out,
  output logic              full
);

  // Holding register and occupancy flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      pc_out   <= '0;
      full     <= 1'b0;
    end else if (clear) begin
      full     <= 1'b0;
    end else if (load) begin
      data_out <= data_in;
      pc_out   <= pc_in;
      full     <= 1'b1;
    end else if (unload) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID pipeline register.
// Owns the PC, issues one outstanding read at a time, and presents
// Inst/PcPlusFour/inst_valid. Honours the IFIDWrite stall and EX redirects.
// Optional build macro FETCH_STATS_EN adds fetch_cnt/discard_cnt counters.
//
// state | meaning
// RUN   | request in flight (or being raised after reset); ack goes to output
// STALL | word parked in skid, request dropped until IF/ID consumes
// DRAIN | redirected while a read was pending; wait for its ack and discard it
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = NOP_WORD
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               IFIDWrite,
  input  logic               redirect,
  input  logic [INST_W-1:0]  redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic [INST_W-1:0]  Inst,
  output logic [INST_W-1:0]  PcPlusFour,
  output logic               inst_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        discard_cnt
`endif
);

  fetch_state_t      state, state_nx;
  logic [INST_W-1:0] pc, pc_nx;
  logic [INST_W-1:0] target, target_nx;
  logic              req, req_nx;
  logic [INST_W-1:0] inst_nx, ppf_nx;
  logic              valid_nx;
  logic [INST_W-1:0] pc_plus4;
  logic              slot_free;
  logic              ack;
  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [INST_W-1:0] skid_data, skid_pc;

  assign pc_plus4       = pc + 32'd4;
  assign slot_free      = !inst_valid || IFIDWrite;
  assign ack            = req && imem.imem_ack;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  fetch_skid_buf u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .data_in  (imem.imem_rdata),
    .pc_in    (pc_plus4),
    .data_out (skid_data),
    .pc_out   (skid_pc),
    .full     (skid_full)
  );

  // Next-state, PC, request and output-slot decisions; redirect wins over all.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    target_nx   = target;
    req_nx      = req;
    inst_nx     = Inst;
    ppf_nx      = PcPlusFour;
    valid_nx    = inst_valid;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (redirect) begin
      valid_nx   = 1'b0;
      inst_nx    = NOP_INST;
      skid_clear = 1'b1;
      if (req && !ack) begin
        // Cannot abort the read; remember where to go once it lands.
        state_nx  = DRAIN;
        target_nx = word_align(redirect_pc);
      end else begin
        state_nx = RUN;
        pc_nx    = word_align(redirect_pc);
        req_nx   = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (!req) begin
            req_nx = 1'b1;
            if (slot_free) begin
              valid_nx = 1'b0;
              inst_nx  = NOP_INST;
            end
          end else if (ack) begin
            pc_nx = pc_plus4;
            if (slot_free) begin
              inst_nx  = imem.imem_rdata;
              ppf_nx   = pc_plus4;
              valid_nx = 1'b1;
            end else begin
              skid_load = 1'b1;
              req_nx    = 1'b0;
              state_nx  = STALL;
            end
          end else if (slot_free) begin
            valid_nx = 1'b0;
            inst_nx  = NOP_INST;
          end
        end
        STALL: begin
          if (IFIDWrite && skid_full) begin
            inst_nx     = skid_data;
            ppf_nx      = skid_pc;
            valid_nx    = 1'b1;
            skid_unload = 1'b1;
            req_nx      = 1'b1;
            state_nx    = RUN;
          end
        end
        DRAIN: begin
          if (ack) begin
            pc_nx    = target;
            req_nx   = 1'b1;
            state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  // State, PC, request and IF/ID output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      target     <= RESET_PC;
      req        <= 1'b0;
      Inst       <= NOP_INST;
      PcPlusFour <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      target     <= target_nx;
      req        <= req_nx;
      Inst       <= inst_nx;
      PcPlusFour <= ppf_nx;
      inst_valid <= valid_nx;
    end
  end

`ifdef FETCH_STATS_EN
  logic fetch_inc, discard_inc;

  // Accepted acks happen only in RUN without redirect; every other ack is dropped.
  always_comb begin
    fetch_inc   = ack && !redirect && (state == RUN);
    discard_inc = ack && (redirect || (state == DRAIN));
  end

  // Free-running statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (fetch_inc)   fetch_cnt   <= fetch_cnt + 32'd1;
      if (discard_inc) discard_cnt <= discard_cnt + 32'd1;
    end
  end
`endif

endmodule
